// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: gap code, direction-symbol bit positions,
// traceback state encoding and the move-selection rule.
package nw_pkg;

  localparam logic [2:0] GAP      = 3'd4;
  localparam int         SYM_DIAG = 2;
  localparam int         SYM_UP   = 1;
  localparam int         SYM_LEFT = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } tr_state_e;

  typedef enum logic [1:0] {
    MV_NONE = 2'd0,
    MV_DIAG = 2'd1,
    MV_UP   = 2'd2,
    MV_LEFT = 2'd3
  } move_e;

  // Border cells force the only legal move; inside the matrix diag > up > left.
  function automatic move_e select_move(input logic [2:0] sym,
                                        input logic       i_zero,
                                        input logic       j_zero);
    move_e mv;
    if (i_zero && !j_zero) begin
      mv = MV_LEFT;
    end else if (j_zero && !i_zero) begin
      mv = MV_UP;
    end else if (sym[SYM_DIAG]) begin
      mv = MV_DIAG;
    end else if (sym[SYM_UP]) begin
      mv = MV_UP;
    end else if (sym[SYM_LEFT]) begin
      mv = MV_LEFT;
    end else begin
      mv = MV_NONE;
    end
    return mv;
  endfunction

endpackage

// File: rtl/traceback_addr_gen.sv
// Traceback cell tracker: holds (i,j) and the matching row-major matrix address,
// updated by constant decrements so no multiplier is needed.
module traceback_addr_gen
  import nw_pkg::*;
#(
  parameter int N  = 128,
  parameter int IW = 9,
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  move_e         move_i,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          last_o
);

  localparam logic [IW-1:0] IDX_N      = IW'(N);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] IDX_ZERO   = IW'(0);
  localparam logic [AW-1:0] ADDR_START = AW'((N + 1) * (N + 1) - 1);
  localparam logic [AW-1:0] STEP_DIAG  = AW'(N + 2);
  localparam logic [AW-1:0] STEP_UP    = AW'(N + 1);
  localparam logic [AW-1:0] STEP_LEFT  = AW'(1);
  localparam logic [AW-1:0] ADDR_ZERO  = AW'(0);

  logic [IW-1:0] i_q, i_d, i_mv_s;
  logic [IW-1:0] j_q, j_d, j_mv_s;
  logic [AW-1:0] addr_q, addr_d, addr_mv_s;

  // Cell reached by applying the pending move, and the load/step selection.
  always_comb begin
    i_mv_s    = i_q;
    j_mv_s    = j_q;
    addr_mv_s = addr_q;
    case (move_i)
      MV_DIAG: begin
        i_mv_s    = i_q - IDX_ONE;
        j_mv_s    = j_q - IDX_ONE;
        addr_mv_s = addr_q - STEP_DIAG;
      end
      MV_UP: begin
        i_mv_s    = i_q - IDX_ONE;
        addr_mv_s = addr_q - STEP_UP;
      end
      MV_LEFT: begin
        j_mv_s    = j_q - IDX_ONE;
        addr_mv_s = addr_q - STEP_LEFT;
      end
      default: begin
        i_mv_s    = i_q;
        j_mv_s    = j_q;
        addr_mv_s = addr_q;
      end
    endcase

    if (load_i) begin
      i_d    = IDX_N;
      j_d    = IDX_N;
      addr_d = ADDR_START;
    end else if (step_i) begin
      i_d    = i_mv_s;
      j_d    = j_mv_s;
      addr_d = addr_mv_s;
    end else begin
      i_d    = i_q;
      j_d    = j_q;
      addr_d = addr_q;
    end
  end

  // Index and address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q    <= IDX_ZERO;
      j_q    <= IDX_ZERO;
      addr_q <= ADDR_ZERO;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      addr_q <= addr_d;
    end
  end

  assign i_o       = i_q;
  assign j_o       = j_q;
  assign rd_addr_o = addr_q;
  assign last_o    = (i_mv_s == IDX_ZERO) && (j_mv_s == IDX_ZERO);

endmodule

// File: rtl/traceback_reader.sv
// Walks the direction matrix from (N,N) back to (0,0), emitting one aligned
// residue pair per step through a valid/ready handshake.
module traceback_reader
  import nw_pkg::*;
#(
  parameter int N           = 128,
  parameter int BitAddr     = $clog2(N + 1),
  parameter int addr_lenght = $clog2(((N + 1) * (N + 1)) - 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   rd_en,
  output logic [addr_lenght-1:0] rd_addr,
  input  logic [2:0]             rd_symbol,
  output logic [BitAddr:0]       seq_addr_a,
  output logic [BitAddr:0]       seq_addr_b,
  input  logic [2:0]             a,
  input  logic [2:0]             b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_a,
  output logic [2:0]             out_b,
  output logic [BitAddr:0]       i,
  output logic [BitAddr:0]       j,
  output logic [BitAddr+1:0]     align_len,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam logic [BitAddr:0]   IDX_ONE  = {{BitAddr{1'b0}}, 1'b1};
  localparam logic [BitAddr:0]   IDX_ZERO = {(BitAddr + 1){1'b0}};
  localparam logic [BitAddr+1:0] LEN_ONE  = {{(BitAddr + 1){1'b0}}, 1'b1};
  localparam logic [BitAddr+1:0] LEN_ZERO = {(BitAddr + 2){1'b0}};

  tr_state_e state_q, state_d;
  move_e     move_q, move_d, mv_s;
  logic      rd_en_q, rd_en_d;
  logic      out_valid_q, out_valid_d;
  logic [2:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [BitAddr+1:0] align_len_q, align_len_d;
  logic      busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic      load_s, step_s, last_s;

  traceback_addr_gen #(
    .N (N),
    .IW(BitAddr + 1),
    .AW(addr_lenght)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_s),
    .step_i   (step_s),
    .move_i   (move_q),
    .i_o      (i),
    .j_o      (j),
    .rd_addr_o(rd_addr),
    .last_o   (last_s)
  );

  assign seq_addr_a = i - IDX_ONE;
  assign seq_addr_b = j - IDX_ONE;

  // Next-state, move capture and output-register next values.
  always_comb begin
    state_d     = state_q;
    move_d      = move_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    align_len_d = align_len_q;
    load_s      = 1'b0;
    step_s      = 1'b0;
    mv_s        = select_move(rd_symbol, i == IDX_ZERO, j == IDX_ZERO);

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          load_s      = 1'b1;
          align_len_d = LEN_ZERO;
          state_d     = ST_READ;
        end else begin
          state_d = state_q;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        case (mv_s)
          MV_DIAG: begin out_a_d = a;   out_b_d = b;   end
          MV_UP:   begin out_a_d = a;   out_b_d = GAP; end
          MV_LEFT: begin out_a_d = GAP; out_b_d = b;   end
          default: begin out_a_d = out_a_q; out_b_d = out_b_q; end
        endcase
        if (mv_s == MV_NONE) begin
          state_d = ST_ERR;
        end else begin
          state_d     = ST_EMIT;
          out_valid_d = 1'b1;
          move_d      = mv_s;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          align_len_d = align_len_q + LEN_ONE;
          step_s      = 1'b1;
          state_d     = last_s ? ST_DONE : ST_READ;
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_en_d = (state_d == ST_READ);
    busy_d  = (state_d == ST_READ) || (state_d == ST_WAIT) || (state_d == ST_EMIT);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERR);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      move_q      <= MV_NONE;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= 3'd0;
      out_b_q     <= 3'd0;
      align_len_q <= LEN_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      move_q      <= move_d;
      rd_en_q     <= rd_en_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      align_len_q <= align_len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign align_len = align_len_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_traceback_reader.sv
// Bench for traceback_reader at N=4: directed and random matrices checked
// against a path-walking reference model.
module tb_traceback_reader;

  localparam int N  = 4;
  localparam int BA = $clog2(N + 1);
  localparam int AW = $clog2(((N + 1) * (N + 1)) - 1);
  localparam int GAPC = 4;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [2:0] rd_symbol = 3'd0, a = 3'd0, b = 3'd0;
  logic rd_en, out_valid, busy, done, error;
  logic [AW-1:0] rd_addr;
  logic [BA:0] seq_addr_a, seq_addr_b, i, j;
  logic [2:0] out_a, out_b;
  logic [BA+1:0] align_len;

  traceback_reader #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_symbol(rd_symbol), .seq_addr_a(seq_addr_a), .seq_addr_b(seq_addr_b),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .i(i), .j(j), .align_len(align_len),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int sym_mem[32];
  int a_mem[16];
  int b_mem[16];

  // Memories answer one cycle after a read strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_symbol <= 3'(sym_mem[rd_addr]);
      a         <= 3'(a_mem[seq_addr_a]);
      b         <= 3'(b_mem[seq_addr_b]);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  int e_addr[16], e_i[16], e_j[16], e_oa[16], e_ob[16];
  int e_reads, e_pairs;
  int e_err;

  // Reference: walk the path from (N,N) using the traceback rules directly.
  function automatic void build_model();
    int ii, jj, s, mv;
    ii = N; jj = N; e_reads = 0; e_pairs = 0; e_err = 0;
    while (!(ii == 0 && jj == 0)) begin
      e_addr[e_reads] = ii * (N + 1) + jj;
      e_i[e_reads] = ii;
      e_j[e_reads] = jj;
      e_reads++;
      s = sym_mem[ii * (N + 1) + jj];
      if (ii == 0) mv = 3;
      else if (jj == 0) mv = 2;
      else if ((s & 4) != 0) mv = 1;
      else if ((s & 2) != 0) mv = 2;
      else if ((s & 1) != 0) mv = 3;
      else mv = 0;
      if (mv == 0) begin
        e_err = 1;
        break;
      end
      if (mv == 1) begin
        e_oa[e_pairs] = a_mem[ii - 1]; e_ob[e_pairs] = b_mem[jj - 1]; ii--; jj--;
      end else if (mv == 2) begin
        e_oa[e_pairs] = a_mem[ii - 1]; e_ob[e_pairs] = GAPC; ii--;
      end else begin
        e_oa[e_pairs] = GAPC; e_ob[e_pairs] = b_mem[jj - 1]; jj--;
      end
      e_pairs++;
    end
  endfunction

  function automatic void fill_diag();
    for (int k = 0; k < 32; k++) sym_mem[k] = 4;
    for (int k = 0; k < 16; k++) begin
      a_mem[k] = k % 4;
      b_mem[k] = k % 4;
    end
  endfunction

  function automatic void fill_random(input int zero_pct);
    for (int k = 0; k < 32; k++)
      sym_mem[k] = ($urandom_range(0, 99) < zero_pct) ? 0 : int'($urandom_range(1, 7));
    for (int k = 0; k < 16; k++) begin
      a_mem[k] = int'($urandom_range(0, 3));
      b_mem[k] = int'($urandom_range(0, 3));
    end
  endfunction

  // mode 0: ready high, 1: random ready, 2: five-cycle stall on the first pair
  // with a start pulse inside the stall.
  task automatic run_and_check(input string name, input int mode);
    int rk, pk, cyc, stall;
    bit fin;
    rk = 0; pk = 0; cyc = 0; stall = 0; fin = 1'b0;
    build_model();
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < 400) begin
      if (mode == 1) begin
        out_ready = 1'($urandom_range(0, 1));
      end else if (mode == 2) begin
        if (out_valid && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
        end
        start = (stall == 3) ? 1'b1 : 1'b0;
      end else begin
        out_ready = 1'b1;
      end
      if (rd_en) begin
        if (rk < e_reads) begin
          check({name, "/rd_addr"}, 32'(rd_addr), e_addr[rk]);
          check({name, "/i"}, 32'(i), e_i[rk]);
          check({name, "/j"}, 32'(j), e_j[rk]);
        end else begin
          check({name, "/read_count"}, rk + 1, e_reads);
        end
        rk++;
      end
      if (out_valid) begin
        if (pk < e_pairs) begin
          check({name, "/out_a"}, 32'(out_a), e_oa[pk]);
          check({name, "/out_b"}, 32'(out_b), e_ob[pk]);
          check({name, "/align_len_hold"}, 32'(align_len), pk);
        end else begin
          check({name, "/pair_count"}, pk + 1, e_pairs);
        end
        if (out_ready) pk++;
      end
      if (done || error) begin
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({name, "/finished"}, 32'(fin), 1);
    check({name, "/reads"}, rk, e_reads);
    check({name, "/pairs"}, pk, e_pairs);
    check({name, "/done"}, 32'(done), (e_err == 0) ? 1 : 0);
    check({name, "/error"}, 32'(error), e_err);
    check({name, "/align_len"}, 32'(align_len), e_pairs);
    check({name, "/busy"}, 32'(busy), 0);
    check({name, "/out_valid"}, 32'(out_valid), 0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "/i"}, 32'(i), 0);
    check({name, "/j"}, 32'(j), 0);
    check({name, "/rd_addr"}, 32'(rd_addr), 0);
    check({name, "/rd_en"}, 32'(rd_en), 0);
    check({name, "/out_valid"}, 32'(out_valid), 0);
    check({name, "/out_a"}, 32'(out_a), 0);
    check({name, "/out_b"}, 32'(out_b), 0);
    check({name, "/align_len"}, 32'(align_len), 0);
    check({name, "/busy"}, 32'(busy), 0);
    check({name, "/done"}, 32'(done), 0);
    check({name, "/error"}, 32'(error), 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start = 1'b0; out_ready = 1'b0;
    fill_diag();
    #12;
    check_reset_values("reset");
    @(negedge clk); rst = 1'b1;

    fill_diag();
    run_and_check("all_diag", 0);

    fill_diag(); sym_mem[24] = 2;
    run_and_check("up_first", 0);

    fill_diag(); sym_mem[18] = 2; sym_mem[7] = 2;
    run_and_check("forced_left", 0);

    fill_diag();
    run_and_check("stall", 2);

    fill_diag(); sym_mem[24] = 2; sym_mem[13] = 0;
    run_and_check("zero_symbol", 0);
    sym_mem[13] = 4;
    run_and_check("restart_after_err", 0);

    // Reset while holding a pair in EMIT.
    fill_diag();
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_emit/reached", 32'(out_valid), 1);
    rst = 1'b0;
    #1;
    check_reset_values("rst_emit");
    @(negedge clk); rst = 1'b1;
    run_and_check("after_rst", 0);

    for (int r = 0; r < 6; r++) begin
      fill_random(0);
      run_and_check($sformatf("rand%0d", r), 1);
    end
    for (int r = 0; r < 4; r++) begin
      fill_random(15);
      run_and_check($sformatf("rand_err%0d", r), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
